// File: rtl/sw_debounce.sv
// sw_debounce: synchronise, debounce and edge-detect active-low switch inputs
module sw_debounce #(
  parameter int          N            = 4,
  parameter logic [25:0] TICK_CNT     = 26'd49,
  parameter int          STABLE_TICKS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] sw_in,
  output logic [N-1:0] sw_level,
  output logic [N-1:0] sw_press,
  output logic [N-1:0] sw_release,
  output logic [7:0]   press_total
);
  localparam logic [3:0] LAST = 4'(STABLE_TICKS - 1);
  logic [N-1:0]      sync1_q, sync2_q, raw_p, flip;
  logic [N-1:0]      level_q, level_d, press_q, press_d, release_q, release_d;
  logic [N-1:0][3:0] cnt_q, cnt_d;
  logic [25:0]       presc_q, presc_d;
  logic [7:0]        total_q, total_d;
  logic              tick;
  // shared prescaler tick, per-channel stability counting and level flips
  always_comb begin
    raw_p = ~sync2_q;
    tick = presc_q == TICK_CNT;
    presc_d = tick ? '0 : presc_q + 26'd1;
    flip = '0;
    cnt_d = cnt_q;
    total_d = total_q;
    for (int i = 0; i < N; i++) begin
      flip[i] = raw_p[i] != level_q[i] && tick && cnt_q[i] == LAST;
      cnt_d[i] = (raw_p[i] == level_q[i] || flip[i]) ? 4'd0 : tick ? cnt_q[i] + 4'd1 : cnt_q[i];
      total_d = total_d + 8'(flip[i] & raw_p[i]);
    end
    level_d = level_q ^ flip;
    press_d = flip & raw_p;
    release_d = flip & ~raw_p;
  end
  // state registers; synchroniser idles at released (1)
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
      presc_q <= '0;
      cnt_q <= '0;
      level_q <= '0;
      press_q <= '0;
      release_q <= '0;
      total_q <= '0;
    end else begin
      sync1_q <= sw_in;
      sync2_q <= sync1_q;
      presc_q <= presc_d;
      cnt_q <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      release_q <= release_d;
      total_q <= total_d;
    end
  end
  assign sw_level = level_q;
  assign sw_press = press_q;
  assign sw_release = release_q;
  assign press_total = total_q;
endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: directed and random stimulus checked against a behavioural debounce model
module tb_sw_debounce;
  localparam int N = 4;
  localparam int T = 49;
  localparam int S = 4;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] sw_in = '1;
  logic [N-1:0] sw_level, sw_press, sw_release;
  logic [7:0]   press_total;
  logic [N-1:0] m_s1, m_s2, m_lvl, m_prs, m_rel;
  logic [7:0]   m_tot;
  int           m_ticks [N];
  int           m_cyc;
  int           n_assert = 0;
  int           n_fail = 0;
  int           np, nr;
  sw_debounce #(.N(N), .TICK_CNT(26'd49), .STABLE_TICKS(S)) dut (
    .clk(clk),
    .rst(rst),
    .sw_in(sw_in),
    .sw_level(sw_level),
    .sw_press(sw_press),
    .sw_release(sw_release),
    .press_total(press_total)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // one clock: drive inputs, advance the model by one edge, compare every output
  task automatic step(input logic r, input logic [N-1:0] s);
    logic tk, rp;
    rst = r;
    sw_in = s;
    @(posedge clk);
    #1;
    if (r) begin
      m_s1 = '1; m_s2 = '1; m_lvl = '0; m_prs = '0; m_rel = '0; m_tot = '0; m_cyc = 0;
      for (int i = 0; i < N; i++) m_ticks[i] = 0;
    end else begin
      tk = (m_cyc % (T + 1)) == T;
      m_prs = '0;
      m_rel = '0;
      for (int i = 0; i < N; i++) begin
        rp = ~m_s2[i];
        if (rp == m_lvl[i]) m_ticks[i] = 0;
        else if (tk) begin
          m_ticks[i]++;
          if (m_ticks[i] == S) begin
            m_lvl[i] = rp;
            m_ticks[i] = 0;
            if (rp) begin m_prs[i] = 1'b1; m_tot++; end
            else m_rel[i] = 1'b1;
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = s;
      m_cyc++;
    end
    if (|sw_press) np++;
    if (|sw_release) nr++;
    chk("sw_level", 32'(sw_level), 32'(m_lvl));
    chk("sw_press", 32'(sw_press), 32'(m_prs));
    chk("sw_release", 32'(sw_release), 32'(m_rel));
    chk("press_total", 32'(press_total), 32'(m_tot));
  endtask
  // hold s until the DUT level equals want (bounded) and check the latency window
  task automatic await_level(input string tag, input logic [N-1:0] s, input logic [N-1:0] want);
    int n;
    n = 0;
    do begin
      step(1'b0, s);
      n++;
    end while (sw_level !== want && n < 300);
    chk({tag, "_level"}, 32'(sw_level), 32'(want));
    chk({tag, "_latency_in_153_203"}, 32'(n >= 153 && n <= 203), 32'd1);
  endtask
  initial begin
    repeat (3) step(1'b1, '1);
    chk("reset_level", 32'(sw_level), 32'd0);
    chk("reset_total", 32'(press_total), 32'd0);
    repeat (10) step(1'b0, '1);
    np = 0;
    await_level("press0", 4'b1110, 4'b0001);
    chk("press0_pulse", 32'(sw_press), 32'h1);
    chk("press0_total", 32'(press_total), 32'd1);
    repeat (60) step(1'b0, 4'b1110);
    chk("press0_pulse_count", 32'(np), 32'd1);
    np = 0;
    nr = 0;
    for (int k = 0; k < 10; k++) begin
      repeat (20) step(1'b0, 4'b1100);
      repeat (20) step(1'b0, 4'b1110);
    end
    chk("bounce_level", 32'(sw_level), 32'h1);
    chk("bounce_press_count", 32'(np), 32'd0);
    chk("bounce_release_count", 32'(nr), 32'd0);
    chk("bounce_total", 32'(press_total), 32'd1);
    nr = 0;
    await_level("release0", 4'b1111, 4'b0000);
    chk("release0_pulse", 32'(sw_release), 32'h1);
    repeat (60) step(1'b0, 4'b1111);
    chk("release0_pulse_count", 32'(nr), 32'd1);
    chk("release0_total", 32'(press_total), 32'd1);
    await_level("simul", 4'b0000, 4'b1111);
    chk("simul_pulse", 32'(sw_press), 32'hf);
    chk("simul_total", 32'(press_total), 32'd5);
    await_level("simul_rel", 4'b1111, 4'b0000);
    for (int k = 0; k < 40; k++) begin
      logic [N-1:0] s;
      s = N'($urandom);
      repeat ($urandom_range(1, 250)) step(1'b0, s);
    end
    repeat (300) step(1'b0, '1);
    chk("random_settled", 32'(sw_level), 32'd0);
    step(1'b1, '1);
    for (int k = 0; k < 64; k++) begin
      await_level("wrap_p", 4'b0000, 4'b1111);
      if (k == 62) chk("wrap_252", 32'(press_total), 32'd252);
      await_level("wrap_r", 4'b1111, 4'b0000);
    end
    chk("wrap_total", 32'(press_total), 32'd0);
    await_level("press2", 4'b1011, 4'b0100);
    nr = 0;
    step(1'b1, 4'b1011);
    chk("rst_mid_level", 32'(sw_level), 32'd0);
    chk("rst_mid_release", 32'(sw_release), 32'd0);
    chk("rst_mid_total", 32'(press_total), 32'd0);
    await_level("repress2", 4'b1011, 4'b0100);
    chk("repress2_pulse", 32'(sw_press), 32'h4);
    chk("repress2_total", 32'(press_total), 32'd1);
    chk("repress2_no_release", 32'(nr), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/sw_debounce.md
# sw_debounce

Multi-channel push-button/slide-switch input conditioner. It is the input-side counterpart of the LED blinker: that block drives board LEDs from a prescaled counter, and this block reads board buttons through the same kind of prescaled tick. Raw active-low pad inputs are synchronised and debounced with a shared prescaler tick. The block produces clean active-high levels, one-cycle press/release pulses and a wrapping press-event counter for downstream control logic.

## Interface
- `N`, default 4: number of input channels (1..8).
- `TICK_CNT`, default 26'd49: prescaler terminal count. A tick occurs every TICK_CNT+1 clocks. Use 26'd49999 for 1 ms at 50 MHz; 49 is the simulation value.
- `STABLE_TICKS`, default 4: consecutive ticks an input must disagree with the debounced level before that level flips (2..15).
- `clk`, input, 1: 50 MHz system clock.
- `rst`, input, 1: reset. Synchronous, active-high.
- `sw_in`, input, N: raw pad inputs, active-low (0 = pressed), asynchronous to `clk`.
- `sw_level`, output, N: debounced state, 1 = pressed.
- `sw_press`, output, N: one-cycle pulse when `sw_level[i]` goes 0→1.
- `sw_release`, output, N: one-cycle pulse when `sw_level[i]` goes 1→0.
- `press_total`, output, 8: running count of press events across all channels, wraps modulo 256.

## Operation
- **Clock and reset:** the only clock is `clk`, and `rst` is sampled only on `clk` edges.
- **Synchroniser:** two flops per channel. Both reset to 1 (released). The synchronised value is inverted to form `raw_p[i]` (1 = pressed).
- **Prescaler:** a 26-bit counter runs 0..TICK_CNT and wraps to 0.
  - `tick` is high for exactly the one cycle in which the counter equals TICK_CNT.
  - The prescaler free-runs and is shared by all channels.
- **Per-channel stability counter:** 4 bits, reset to 0.
  - If `raw_p[i] == sw_level[i]` in any cycle, the counter clears to 0. This happens on every cycle, not only on ticks.
  - Else, if `tick` is high and the counter equals STABLE_TICKS-1: `sw_level[i]` toggles, the counter clears, and the matching pulse fires.
  - Else, if `tick` is high: the counter increments.
  - Else: the counter holds.
- **Pulses:** `sw_press`/`sw_release` are registered and assert in the same cycle `sw_level` changes. They are high for exactly one cycle and never both high on the same channel.
- **Event counter:** `press_total` adds popcount(`sw_press`) each cycle, so simultaneous presses on k channels add k. 8-bit arithmetic, 255+1 → 0.
- **Channel independence:** channels are independent and may flip in the same cycle.

## Timing
- **Reset values** (on the first edge with `rst`=1):
  - `sw_level`, `sw_press`, `sw_release`, `press_total`: 0.
  - Prescaler: 0.
  - Stability counters: 0.
  - Synchroniser flops: 1.
- **After reset release:** the prescaler reaches TICK_CNT TICK_CNT+1 cycles later. Ticks then repeat every TICK_CNT+1 cycles.
- **Latency:**
  - Raw edge to `raw_p`: 2 cycles.
  - `raw_p` mismatch to `sw_level` flip: on the STABLE_TICKS-th tick after the mismatch begins. The flip is visible the cycle after that tick.
  - Total latency lies in [2 + (STABLE_TICKS-1)(TICK_CNT+1) + 1, 2 + STABLE_TICKS(TICK_CNT+1) + 1] cycles. With the defaults this is [153, 203].
- **Glitch rejection:** a bounce shorter than the gap to the next tick, or any return to the current level before STABLE_TICKS ticks, produces no level change and no pulse.
- **Reset mid-operation:** partial counts are discarded and all outputs drop to 0 on that edge, with no release pulse. A button still held when reset is released is re-debounced and produces a fresh `sw_press` and `press_total` increment.
- **Constant input:** `sw_in` held at 1 from reset produces no activity forever.

## Test plan
- **Clean press (defaults):** hold reset for 3 cycles. Drive `sw_in`=4'b1110 (ch0 pressed) 10 cycles after release and hold.
  - Required: `sw_level`=4'b0001 within 153..203 cycles of the edge.
  - `sw_press`=4'b0001 for exactly 1 cycle; `press_total`=1.
- **Bounce rejection:** toggle ch1 low/high every 20 cycles for 400 cycles, ending high.
  - Required: `sw_level[1]`=0 throughout; no pulses; `press_total` unchanged.
- **Release:** from the pressed state, set ch0 high and hold.
  - Required: `sw_release[0]` pulses once 153..203 cycles later.
  - `sw_level[0]`=0; `press_total` unchanged.
- **Simultaneous press:** drive all 4 channels low in the same cycle.
  - Required: all pulses in the same cycle; `press_total` increases by exactly 4.
- **Wrap:** perform 256 single-channel presses.
  - Required: `press_total` returns to 0 after the 256th press.
- **Reset mid-press:** assert `rst` for 1 cycle while ch2 is debounced-pressed and held.
  - Required: all outputs 0 the next cycle, with no release pulse.
  - Then a new `sw_press[2]` within 153..203 cycles and `press_total`=1.
